sent_tx_frame_ctrl: RTL and testbench
=====================================

Name: sent_tx_frame_ctrl

Overview:
- Transmit-side SENT frame sequencer.
- Requests fast-channel data from the TX data register via load_bit and waits for done_pre_data.
- Packs the data_f1/data_f2 words into data nibbles per format and computes the SENT CRC4.
- Streams sync/status/data/CRC nibbles over a valid/ready interface to the tick/pulse generator.

Parameters:
- REQ_TIMEOUT, 64: max cycles in REQ waiting for done_pre_data before abort.
- TMO_W, 7: timeout counter width; must satisfy 2^TMO_W > REQ_TIMEOUT.

Ports:
- clk_tx  in  1  clock.
- reset_n_tx  in  1  reset, asynchronous, active-low.
- enable_i  in  1  run frames continuously while high.
- mode_i  in  3  format select (001..111); 000 = disabled.
- status_nib_i  in  4  status/comm nibble, sampled at frame start.
- load_bit_o  out  3  format request to the data register; 000 when not requesting.
- done_pre_data_i  in  1  1-cycle pulse; data_f1_i/data_f2_i valid in the same cycle.
- data_f1_i  in  16  fast channel 1 word.
- data_f2_i  in  12  fast channel 2 word.
- nib_o  out  4  nibble value.
- nib_type_o  out  2  00 sync, 01 status, 10 data, 11 crc.
- nib_valid_o  out  1  nibble offered.
- nib_ready_i  in  1  pulse generator accepts the nibble.
- frame_done_o  out  1  1-cycle pulse when the CRC nibble is accepted.
- frame_err_o  out  1  1-cycle pulse on REQ timeout.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC register 4'h5, counters 0.
- States: IDLE, REQ, SYNC, STATUS, DATA, CRC.
- IDLE: if enable_i && mode_i != 000, latch mode and status_nib_i, then go to REQ next cycle.
- REQ: load_bit_o = latched mode, timeout counter increments each cycle.
  - On done_pre_data_i: capture data into a 24-bit shift word, set nibble count, go to SYNC. load_bit_o is 000 from the next cycle.
  - When the counter reaches REQ_TIMEOUT without done: pulse frame_err_o, go to IDLE, load_bit_o = 000.
- Packing, MSN first:
  - 001: {f1[11:0], f2[11:0]}, 6 nibbles.
  - 110: {f1[13:0], f2[9:0]}, 6 nibbles.
  - 111: {f1[15:0], f2[7:0]}, 6 nibbles.
  - 010, 101: f1[11:0], 3 nibbles.
  - 011, 100: {f1[11:0], ~f1[11:8]}, 4 nibbles.
- SYNC: nib_o = 0, type 00. STATUS: nib_o = latched status, type 01.
- DATA: one nibble per handshake, type 10. The shift word shifts left 4 on each accept. Each accept updates crc <= nib ^ T[crc].
- CRC: nib_o = T[crc] (zero-nibble augmentation), type 11. On accept, pulse frame_done_o, reset CRC to 5.
  - Then go to REQ if enable_i && mode_i != 000, latching the new mode/status; otherwise go to IDLE.
- CRC table, poly x^4+x^3+x^2+1: T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
- Handshake rules:
  - nib_valid_o is 1 in SYNC/STATUS/DATA/CRC.
  - nib_o and nib_type_o stay stable until nib_valid_o && nib_ready_i.
  - The state advances only on that accept.
  - ready held high gives 1 nibble/cycle.
- enable_i falling mid-frame: the frame completes fully, no truncation.
- mode_i or status_nib_i changing mid-frame: ignored until the next latch.
- done_pre_data_i outside REQ: ignored.
- reset_n_tx asserted mid-frame: immediate return to reset values, no partial frame resumes.
- Latency: done pulse → SYNC valid in 1 cycle. CRC accept → next load_bit_o in 1 cycle.

Decomposition:
- Shared package sent_tx_pkg holds:
  - mode encodings (MODE_2X12=001 … MODE_16_8=111);
  - nibble type codes;
  - CRC4 table function;
  - CRC_SEED = 4'h5;
  - state enum.
- One sub-module: sent_tx_crc4, a combinational step (crc_in, nib_in → crc_out), reused for the augmentation with nib = 0.

Test Plan:
- Mode 010, f1 = 12'h000, status 4'h3, ready = 1 → nibbles sync 0, status 3, data 0,0,0, crc 4'h9; one frame_done_o pulse.
- Mode 001, f1 = 12'hABC, f2 = 12'h123 → data A,B,C,1,2,3 in order; CRC equals the software model; load_bit_o = 001 until the done cycle, then 000.
- Mode 111, f1 = 16'hFEDC, f2 = 8'h98 → data F,E,D,C,9,8. Mode 011, f1 = 12'h5A3 → data 5,A,3,A.
- nib_ready_i toggled randomly, including ready low for 5 cycles mid-DATA → nib_o/nib_type_o constant while stalled; no nibble lost or duplicated.
- No done_pre_data_i for 64 cycles in REQ → frame_err_o pulses once, state returns to IDLE, no nib_valid_o.
- enable_i dropped during STATUS → frame completes through CRC, then IDLE. reset_n_tx low during DATA → all outputs 0 immediately; clean frame after release.

Source files
------------

// File: rtl/sent_tx_pkg.sv
// Shared definitions for the SENT transmit frame path: format codes,
// nibble type codes, FSM state codes, CRC4 table and data packing.
package sent_tx_pkg;

    // Frame format select codes (mode_i / load_bit_o)
    localparam logic [2:0] MODE_OFF      = 3'b000;
    localparam logic [2:0] MODE_2X12     = 3'b001;
    localparam logic [2:0] MODE_12_A     = 3'b010;
    localparam logic [2:0] MODE_12_INV_A = 3'b011;
    localparam logic [2:0] MODE_12_INV_B = 3'b100;
    localparam logic [2:0] MODE_12_B     = 3'b101;
    localparam logic [2:0] MODE_14_10    = 3'b110;
    localparam logic [2:0] MODE_16_8     = 3'b111;

    // Nibble type codes seen by the pulse generator
    localparam logic [1:0] NIB_SYNC   = 2'b00;
    localparam logic [1:0] NIB_STATUS = 2'b01;
    localparam logic [1:0] NIB_DATA   = 2'b10;
    localparam logic [1:0] NIB_CRC    = 2'b11;

    // CRC register start value for every frame
    localparam logic [3:0] CRC_SEED = 4'h5;

    // Frame sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_SYNC   = 3'd2;
    localparam logic [2:0] ST_STATUS = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CRC    = 3'd5;

    // CRC4 lookup for polynomial x^4+x^3+x^2+1, indexed by the current CRC
    function automatic logic [3:0] crc4_table(input logic [3:0] idx);
        logic [3:0] t;
        case (idx)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

    // Number of data nibbles carried by each format
    function automatic logic [2:0] nib_count(input logic [2:0] mode);
        logic [2:0] n;
        case (mode)
            MODE_2X12, MODE_14_10, MODE_16_8: n = 3'd6;
            MODE_12_INV_A, MODE_12_INV_B:     n = 3'd4;
            MODE_12_A, MODE_12_B:             n = 3'd3;
            default:                          n = 3'd0;
        endcase
        return n;
    endfunction

    // Left-aligned data word; the most significant nibble is sent first
    function automatic logic [23:0] pack_data(input logic [2:0]  mode,
                                              input logic [15:0] f1,
                                              input logic [11:0] f2);
        logic [23:0] w;
        case (mode)
            MODE_2X12:                    w = {f1[11:0], f2};
            MODE_14_10:                   w = {f1[13:0], f2[9:0]};
            MODE_16_8:                    w = {f1, f2[7:0]};
            MODE_12_A, MODE_12_B:         w = {f1[11:0], 12'h000};
            MODE_12_INV_A, MODE_12_INV_B: w = {f1[11:0], ~f1[11:8], 8'h00};
            default:                      w = 24'h000000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sent_tx_crc4.sv
// One combinational SENT CRC4 step: crc_out = nib_in ^ T[crc_in].
// Feeding nib_in = 0 gives the final zero-nibble augmentation.
module sent_tx_crc4
    import sent_tx_pkg::*;
(
    input  logic [3:0] crc_in,
    input  logic [3:0] nib_in,
    output logic [3:0] crc_out
);

    assign crc_out = nib_in ^ crc4_table(crc_in);

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame sequencer: requests fast-channel data, packs it into
// nibbles, runs the CRC4 and streams sync/status/data/CRC nibbles over a
// valid/ready handshake to the pulse generator.
module sent_tx_frame_ctrl
    import sent_tx_pkg::*;
#(
    parameter int REQ_TIMEOUT = 64,
    parameter int TMO_W       = 7
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic        enable_i,
    input  logic [2:0]  mode_i,
    input  logic [3:0]  status_nib_i,
    output logic [2:0]  load_bit_o,
    input  logic        done_pre_data_i,
    input  logic [15:0] data_f1_i,
    input  logic [11:0] data_f2_i,
    output logic [3:0]  nib_o,
    output logic [1:0]  nib_type_o,
    output logic        nib_valid_o,
    input  logic        nib_ready_i,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    // Last REQ count before the request is abandoned
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       mode_q;
    logic [3:0]       status_q;
    logic [23:0]      shift_q;
    logic [2:0]       nib_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       crc_q;
    logic [3:0]       crc_nib_in;
    logic [3:0]       crc_next;
    logic             start_ok;
    logic             accept;

    assign start_ok = enable_i && (mode_i != MODE_OFF);
    assign accept   = nib_valid_o && nib_ready_i;
    assign busy_o   = (state != ST_IDLE);

    // In CRC state the step runs with a zero nibble, giving T[crc] as the checksum
    assign crc_nib_in = (state == ST_DATA) ? shift_q[23:20] : 4'h0;

    sent_tx_crc4 u_crc4 (
        .crc_in  (crc_q),
        .nib_in  (crc_nib_in),
        .crc_out (crc_next)
    );

    // Decode the offered nibble and the data request purely from registered state
    always_comb begin
        load_bit_o  = MODE_OFF;
        nib_o       = 4'h0;
        nib_type_o  = NIB_SYNC;
        nib_valid_o = 1'b0;
        case (state)
            ST_REQ: begin
                load_bit_o = mode_q;
            end
            ST_SYNC: begin
                nib_valid_o = 1'b1;
                nib_type_o  = NIB_SYNC;
            end
            ST_STATUS: begin
                nib_valid_o = 1'b1;
                nib_o       = status_q;
                nib_type_o  = NIB_STATUS;
            end
            ST_DATA: begin
                nib_valid_o = 1'b1;
                nib_o       = shift_q[23:20];
                nib_type_o  = NIB_DATA;
            end
            ST_CRC: begin
                nib_valid_o = 1'b1;
                nib_o       = crc_next;
                nib_type_o  = NIB_CRC;
            end
            default: begin
                load_bit_o = MODE_OFF;
            end
        endcase
    end

    // Frame sequencing, data capture/shift, CRC accumulation and status pulses
    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_OFF;
            status_q     <= 4'h0;
            shift_q      <= 24'h000000;
            nib_cnt      <= 3'd0;
            tmo_cnt      <= '0;
            crc_q        <= CRC_SEED;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        mode_q   <= mode_i;
                        status_q <= status_nib_i;
                        tmo_cnt  <= '0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (done_pre_data_i) begin
                        shift_q <= pack_data(mode_q, data_f1_i, data_f2_i);
                        nib_cnt <= nib_count(mode_q);
                        tmo_cnt <= '0;
                        state   <= ST_SYNC;
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err_o <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (accept) begin
                        state <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (accept) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        shift_q <= {shift_q[19:0], 4'h0};
                        crc_q   <= crc_next;
                        nib_cnt <= nib_cnt - 1'b1;
                        if (nib_cnt == 3'd1) begin
                            state <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (accept) begin
                        frame_done_o <= 1'b1;
                        crc_q        <= CRC_SEED;
                        if (start_ok) begin
                            mode_q   <= mode_i;
                            status_q <= status_nib_i;
                            tmo_cnt  <= '0;
                            state    <= ST_REQ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Directed bench for sent_tx_frame_ctrl: frame contents and CRCs for several
// formats, stalled handshakes, back-to-back frames, request timeout and
// mid-frame reset.
module tb_sent_tx_frame_ctrl;

    logic        clk_tx = 1'b0;
    logic        reset_n_tx;
    logic        enable_i;
    logic [2:0]  mode_i;
    logic [3:0]  status_nib_i;
    logic [2:0]  load_bit_o;
    logic        done_pre_data_i;
    logic [15:0] data_f1_i;
    logic [11:0] data_f2_i;
    logic [3:0]  nib_o;
    logic [1:0]  nib_type_o;
    logic        nib_valid_o;
    logic        nib_ready_i;
    logic        frame_done_o;
    logic        frame_err_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_nib [0:9];
    logic [1:0] exp_type[0:9];
    int         exp_n;

    sent_tx_frame_ctrl #(.REQ_TIMEOUT(64), .TMO_W(7)) dut (
        .clk_tx          (clk_tx),
        .reset_n_tx      (reset_n_tx),
        .enable_i        (enable_i),
        .mode_i          (mode_i),
        .status_nib_i    (status_nib_i),
        .load_bit_o      (load_bit_o),
        .done_pre_data_i (done_pre_data_i),
        .data_f1_i       (data_f1_i),
        .data_f2_i       (data_f2_i),
        .nib_o           (nib_o),
        .nib_type_o      (nib_type_o),
        .nib_valid_o     (nib_valid_o),
        .nib_ready_i     (nib_ready_i),
        .frame_done_o    (frame_done_o),
        .frame_err_o     (frame_err_o),
        .busy_o          (busy_o)
    );

    // 100 MHz transmit clock
    always #5 clk_tx = ~clk_tx;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] mode, input logic [3:0] status);
        mode_i       = mode;
        status_nib_i = status;
        enable_i     = 1'b1;
    endtask

    // Expected frame: sync, status, n data nibbles from a left-aligned word, crc
    task automatic set_exp(input logic [3:0] status, input int n,
                           input logic [23:0] data, input logic [3:0] crc);
        exp_nib[0]  = 4'h0;
        exp_type[0] = 2'b00;
        exp_nib[1]  = status;
        exp_type[1] = 2'b01;
        for (int i = 0; i < n; i++) begin
            exp_nib[2 + i]  = data[23 - 4 * i -: 4];
            exp_type[2 + i] = 2'b10;
        end
        exp_nib[2 + n]  = crc;
        exp_type[2 + n] = 2'b11;
        exp_n = n + 3;
    endtask

    // drop_at: 0 = enable dropped in REQ, 1 = dropped while STATUS offered, 2 = kept high
    // ready_mode: 0 = ready held high, 1 = random ready with a 5-cycle stall in DATA
    task automatic collect_frame(input string tag, input logic [2:0] exp_mode,
                                 input logic [15:0] f1, input logic [11:0] f2,
                                 input int ready_mode, input int drop_at);
        int         waitc = 0;
        int         idx = 0;
        int         cyc = 0;
        int         dones = 0;
        int         stall_run = 0;
        logic       stalled = 1'b0;
        logic [3:0] hold_nib = 4'h0;
        logic [1:0] hold_type = 2'b00;

        while (load_bit_o == 3'b000 && waitc < 20) begin
            step();
            waitc++;
        end
        check_output({tag, "_load_bit"}, 32'(load_bit_o), 32'(exp_mode));
        check_output({tag, "_busy_req"}, 32'(busy_o), 32'd1);
        check_output({tag, "_novalid_req"}, 32'(nib_valid_o), 32'd0);
        if (drop_at == 0) enable_i = 1'b0;
        step();
        check_output({tag, "_load_bit_hold"}, 32'(load_bit_o), 32'(exp_mode));

        data_f1_i       = f1;
        data_f2_i       = f2;
        done_pre_data_i = 1'b1;
        step();
        done_pre_data_i = 1'b0;
        data_f1_i       = ~f1;
        data_f2_i       = ~f2;
        if (drop_at != 2) begin
            mode_i       = exp_mode ^ 3'b110;
            status_nib_i = ~status_nib_i;
        end
        check_output({tag, "_load_bit_off"}, 32'(load_bit_o), 32'd0);
        check_output({tag, "_sync_latency"}, 32'({nib_valid_o, nib_type_o}), 32'h4);

        while (idx < exp_n && cyc < 200) begin
            if (stalled && nib_valid_o) begin
                check_output({tag, "_stall_nib"}, 32'(nib_o), 32'(hold_nib));
                check_output({tag, "_stall_type"}, 32'(nib_type_o), 32'(hold_type));
            end
            if (ready_mode == 0) begin
                nib_ready_i = 1'b1;
            end else if (idx == 4 && stall_run < 5) begin
                nib_ready_i = 1'b0;
                stall_run++;
            end else begin
                nib_ready_i = 1'($urandom_range(0, 1));
            end
            if (drop_at == 1 && nib_valid_o && nib_type_o == 2'b01) enable_i = 1'b0;
            if (nib_valid_o && nib_ready_i) begin
                check_output($sformatf("%s_nib%0d", tag, idx), 32'(nib_o), 32'(exp_nib[idx]));
                check_output($sformatf("%s_type%0d", tag, idx), 32'(nib_type_o), 32'(exp_type[idx]));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled   = nib_valid_o;
                hold_nib  = nib_o;
                hold_type = nib_type_o;
            end
            if (frame_done_o) dones++;
            step();
            cyc++;
        end
        nib_ready_i = 1'b1;
        check_output({tag, "_nib_total"}, 32'(idx), 32'(exp_n));
        check_output({tag, "_early_done"}, 32'(dones), 32'd0);
        if (ready_mode == 0) check_output({tag, "_one_per_cycle"}, 32'(cyc), 32'(exp_n));
        check_output({tag, "_frame_done"}, 32'(frame_done_o), 32'd1);
        if (drop_at == 2) begin
            check_output({tag, "_next_req"}, 32'(load_bit_o), 32'(mode_i));
            check_output({tag, "_busy_after"}, 32'(busy_o), 32'd1);
        end else begin
            check_output({tag, "_idle_load"}, 32'(load_bit_o), 32'd0);
            check_output({tag, "_busy_after"}, 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        int waitc;
        int req_cycles;
        int errs;
        int valids;

        reset_n_tx      = 1'b0;
        enable_i        = 1'b0;
        mode_i          = 3'b000;
        status_nib_i    = 4'h0;
        done_pre_data_i = 1'b0;
        data_f1_i       = 16'h0000;
        data_f2_i       = 12'h000;
        nib_ready_i     = 1'b1;
        step();
        step();
        check_output("rst_load_bit", 32'(load_bit_o), 32'd0);
        check_output("rst_valid", 32'(nib_valid_o), 32'd0);
        check_output("rst_nib", 32'({nib_o, nib_type_o}), 32'd0);
        check_output("rst_pulses", 32'({frame_done_o, frame_err_o}), 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        reset_n_tx = 1'b1;
        step();
        check_output("idle_busy", 32'(busy_o), 32'd0);

        $display("[TB] mode 010 all-zero frame");
        apply_stimulus(3'b010, 4'h3);
        set_exp(4'h3, 3, 24'h000000, 4'h9);
        collect_frame("m010", 3'b010, 16'h0000, 12'h000, 0, 0);

        $display("[TB] mode 001 frame");
        apply_stimulus(3'b001, 4'h6);
        set_exp(4'h6, 6, 24'hABC123, 4'hE);
        collect_frame("m001", 3'b001, 16'h0ABC, 12'h123, 0, 0);

        $display("[TB] mode 111 frame");
        apply_stimulus(3'b111, 4'h0);
        set_exp(4'h0, 6, 24'hFEDC98, 4'hD);
        collect_frame("m111", 3'b111, 16'hFEDC, 12'h098, 0, 0);

        $display("[TB] mode 011 frame");
        apply_stimulus(3'b011, 4'hA);
        set_exp(4'hA, 4, 24'h5A3A00, 4'h9);
        collect_frame("m011", 3'b011, 16'h05A3, 12'h000, 0, 0);

        $display("[TB] random ready with stall");
        apply_stimulus(3'b001, 4'h6);
        set_exp(4'h6, 6, 24'hABC123, 4'hE);
        collect_frame("stall", 3'b001, 16'h0ABC, 12'h123, 1, 0);

        $display("[TB] enable dropped during status");
        apply_stimulus(3'b010, 4'h3);
        set_exp(4'h3, 3, 24'h000000, 4'h9);
        collect_frame("drop", 3'b010, 16'h0000, 12'h000, 0, 1);

        $display("[TB] back-to-back frames");
        apply_stimulus(3'b010, 4'h3);
        set_exp(4'h3, 3, 24'h000000, 4'h9);
        collect_frame("b2b_a", 3'b010, 16'h0000, 12'h000, 0, 2);
        collect_frame("b2b_b", 3'b010, 16'h0000, 12'h000, 0, 0);

        $display("[TB] done outside REQ and request timeout");
        step();
        done_pre_data_i = 1'b1;
        step();
        done_pre_data_i = 1'b0;
        check_output("stray_done_busy", 32'(busy_o), 32'd0);
        check_output("stray_done_valid", 32'(nib_valid_o), 32'd0);
        apply_stimulus(3'b001, 4'h1);
        waitc = 0;
        while (load_bit_o == 3'b000 && waitc < 20) begin
            step();
            waitc++;
        end
        enable_i   = 1'b0;
        req_cycles = 0;
        errs       = 0;
        valids     = 0;
        for (int c = 0; c < 100; c++) begin
            if (load_bit_o != 3'b000) req_cycles++;
            if (frame_err_o) errs++;
            if (nib_valid_o) valids++;
            step();
        end
        check_output("tmo_req_cycles", 32'(req_cycles), 32'd64);
        check_output("tmo_err_pulses", 32'(errs), 32'd1);
        check_output("tmo_no_valid", 32'(valids), 32'd0);
        check_output("tmo_idle", 32'(busy_o), 32'd0);

        $display("[TB] reset during DATA");
        apply_stimulus(3'b001, 4'h6);
        nib_ready_i = 1'b1;
        waitc = 0;
        while (load_bit_o == 3'b000 && waitc < 20) begin
            step();
            waitc++;
        end
        data_f1_i       = 16'h0ABC;
        data_f2_i       = 12'h123;
        done_pre_data_i = 1'b1;
        step();
        done_pre_data_i = 1'b0;
        step();
        step();
        step();
        check_output("pre_rst_type", 32'(nib_type_o), 32'h2);
        enable_i = 1'b0;
        #2;
        reset_n_tx = 1'b0;
        #1;
        check_output("mid_rst_load_bit", 32'(load_bit_o), 32'd0);
        check_output("mid_rst_valid", 32'(nib_valid_o), 32'd0);
        check_output("mid_rst_nib", 32'({nib_o, nib_type_o}), 32'd0);
        check_output("mid_rst_pulses", 32'({frame_done_o, frame_err_o}), 32'd0);
        check_output("mid_rst_busy", 32'(busy_o), 32'd0);
        step();
        step();
        reset_n_tx = 1'b1;
        step();
        check_output("post_rst_idle", 32'(busy_o), 32'd0);
        apply_stimulus(3'b010, 4'h3);
        set_exp(4'h3, 3, 24'h000000, 4'h9);
        collect_frame("post_rst", 3'b010, 16'h0000, 12'h000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
